// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard
// Purpose  : Bus-mapped PS/2 keyboard receiver. Deserialises 11-bit PS/2
//            frames into scan-code bytes, buffers them in a FIFO and exposes
//            them through a DATA (addr 0) and STATUS (addr 1) register.
//            Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity
//            and report them through the sticky PERR flag.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] data_bus,
    input  logic       address,
    input  logic       cs_w,
    input  logic       cs_r,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       irq
);
    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam int c_fw = $clog2(FILTER_LEN + 1);
    localparam int c_tw = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    // Input conditioning
    logic            clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic            dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic            filt_q, filt_d;
    logic [c_fw-1:0] filt_cnt_q, filt_cnt_d;
    logic            sample_q, sample_d, samp_bit_q, samp_bit_d;

    // Frame FSM
    logic [1:0]      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [c_tw-1:0] tmo_q, tmo_d;
    logic            push_req, ferr_set, parity_ok;

    // FIFO, flags and bus interface
    logic [7:0]      mem_q [0:FIFO_DEPTH-1];
    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q, count_d;
    logic            ovf_q, ovf_d, ferr_q, ferr_d, irq_q, irq_d;
    logic            rd_q, rd_d, rd_addr_q, rd_addr_d;
    logic            full, not_empty, pop, push_ok, ovf_set, perr_flag;
    logic [2:0]      clr;
    logic [7:0]      rd_data;
    logic            unused_bus;

`ifdef PS2_PARITY_CHECK_EN
    logic            par_q, par_d, perr_q, perr_d, perr_set;
    assign parity_ok = ^{shift_q, par_q};
    assign perr_flag = perr_q;
`else
    logic            unused_clr;
    assign parity_ok  = 1'b1;
    assign perr_flag  = 1'b0;
    assign unused_clr = clr[2];
`endif

    // Synchronise both pins, debounce ps2_clk, pulse on filtered falling edge
    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2_data;
        dat_sync_d = dat_meta_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        sample_d   = 1'b0;
        samp_bit_d = dat_sync_q;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == c_fw'(FILTER_LEN - 1)) begin
                filt_d   = clk_sync_q;
                sample_d = filt_q;      // only the 1->0 change samples data
            end else begin
                filt_cnt_d = filt_cnt_q + c_fw'(1);
            end
        end
    end

    // Conditioning registers; idle level of the PS/2 lines is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            sample_q   <= 1'b0;
            samp_bit_q <= 1'b1;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            sample_q   <= sample_d;
            samp_bit_q <= samp_bit_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= c_st_idle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    // FSM next state: frame walk on sample pulses, timeout abandons partial frames
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        tmo_d     = (state_q == c_st_idle || sample_q) ? '0 : tmo_q + c_tw'(1);
        if (sample_q) begin
            case (state_q)
                c_st_idle: begin
                    if (!samp_bit_q) begin
                        state_d   = c_st_data;
                        bit_cnt_d = '0;
                    end
                end
                c_st_data: begin
                    shift_d   = {samp_bit_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = c_st_parity;
                end
                c_st_parity: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = samp_bit_q;
`endif
                    state_d = c_st_stop;
                end
                default: state_d = c_st_idle;
            endcase
        end else if (state_q != c_st_idle && tmo_q == c_tw'(TIMEOUT - 1)) begin
            state_d = c_st_idle;
        end
    end

    // FSM outputs: frame verdict at the stop bit
    always_comb begin
        push_req = 1'b0;
        ferr_set = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr_set = 1'b0;
`endif
        if (sample_q && state_q == c_st_stop) begin
            if (!samp_bit_q)   ferr_set = 1'b1;
            else if (parity_ok) push_req = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            else               perr_set = 1'b1;
`endif
        end
    end

    // FIFO bookkeeping, pop on the falling edge of a DATA read, sticky flags
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == c_cw'(FIFO_DEPTH));
        pop       = rd_q && !cs_r && !rd_addr_q && not_empty;
        push_ok   = push_req && (!full || pop);
        ovf_set   = push_req && full && !pop;
        wr_ptr_d  = push_ok ? wr_ptr_q + c_pw'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + c_pw'(1) : rd_ptr_q;
        count_d   = count_q + c_cw'(push_ok) - c_cw'(pop);
        rd_d      = cs_r;
        rd_addr_d = cs_r ? address : rd_addr_q;
        clr       = (cs_w && address) ? data_bus[3:1] : 3'b000;
        ovf_d     = ovf_set  | (ovf_q  & ~clr[0]);
        ferr_d    = ferr_set | (ferr_q & ~clr[1]);
`ifdef PS2_PARITY_CHECK_EN
        perr_d    = perr_set | (perr_q & ~clr[2]);
`endif
        irq_d     = not_empty;
    end

    // FIFO and flag registers; reset flushes the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            irq_q     <= 1'b0;
            rd_q      <= 1'b0;
            rd_addr_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
            irq_q     <= irq_d;
            rd_q      <= rd_d;
            rd_addr_q <= rd_addr_d;
`ifdef PS2_PARITY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // Storage array needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    // Read mux drives the shared bus only during a read strobe
    always_comb begin
        if (address) rd_data = {4'b0000, perr_flag, ferr_q, ovf_q, not_empty};
        else         rd_data = not_empty ? mem_q[rd_ptr_q] : 8'h00;
    end

    assign data_bus   = cs_r ? rd_data : 8'bzzzz_zzzz;
    assign irq        = irq_q;
    assign unused_bus = ^{data_bus[7:4], data_bus[0]};

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard
// Purpose  : Self-checking bench for ps2_keyboard; directed scenarios plus a
//            randomized phase compared against a queue-based register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard;
    localparam int DEPTH = 8;
    localparam int FLT   = 4;
    localparam int TMO   = 2000;
    localparam int HALF  = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, address, cs_w, cs_r, ps2_clk, ps2_data;
    logic [7:0] drv;
    logic       drv_en;
    wire  [7:0] data_bus;
    wire        irq;

    assign data_bus = drv_en ? drv : 8'bzzzz_zzzz;
    always #5 clk = ~clk;

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .data_bus(data_bus), .address(address),
        .cs_w(cs_w), .cs_r(cs_r), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .irq(irq)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat_push = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

    function automatic logic [7:0] model_status();
        return {4'b0000, m_perr, m_ferr, m_ovf, q.size() != 0};
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic a, output logic [7:0] v);
        @(negedge clk); address = a; cs_r = 1'b1;
        @(negedge clk); v = data_bus; cs_r = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clk); address = a; drv = d; drv_en = 1'b1; cs_w = 1'b1;
        @(negedge clk); cs_w = 1'b0; drv_en = 1'b0;
        if (a) begin
            if (d[1]) m_ovf  = 1'b0;
            if (d[2]) m_ferr = 1'b0;
            if (d[3]) m_perr = 1'b0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [7:0] v;
        bus_read(1'b1, v);
        check8(tag, v, model_status());
    endtask

    task automatic check_data(input string tag);
        logic [7:0] v, e;
        e = (q.size() != 0) ? q[0] : 8'h00;
        bus_read(1'b0, v);
        if (q.size() != 0) void'(q.pop_front());
        check8(tag, v, e);
    endtask

    // mode 0: plain bit; 1: measure push latency via irq; 2: end a DATA read so its pop meets the push
    task automatic send_bit(input logic b, input int mode);
        logic [7:0] v;
        @(negedge clk); ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (mode == 1 && lat_push == 0 && irq === 1'b1) lat_push = i + 1;
            if (mode == 2 && i == lat_push - 3) begin
                v = data_bus;
                check8("collide_head", v, q[0]);
                cs_r = 1'b0;
                void'(q.pop_front());
            end
        end
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int mode);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0);
        send_bit(par, 0);
        send_bit(stop, mode);
        if (!stop)                          m_ferr = 1'b1;
        else if (PAR_EN && ^{d, par} == 1'b0) m_perr = 1'b1;
        else if (q.size() >= DEPTH)         m_ovf  = 1'b1;
        else                                q.push_back(d);
        repeat (10) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        logic [7:0] v, rb;
        int         op;
        reset = 1'b1; address = 1'b0; cs_w = 1'b0; cs_r = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1; drv = 8'h00; drv_en = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check1("reset_irq", irq, 1'b0);
        check_status("reset_status");
        check_data("reset_data_empty");

        // Basic receive, also calibrates the stop-edge-to-irq latency
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1);
        check_status("basic_status");
        check1("basic_irq", irq, 1'b1);
        check_data("basic_data");
        check_status("basic_status_after");
        check1("basic_irq_after", irq, 1'b0);
        check1("latency_measured", (lat_push >= 3 && lat_push < HALF), 1'b1);

        // Ordering and overflow
        for (int k = 1; k <= 9; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 0);
        check_status("full_status");
        for (int k = 0; k < 8; k++) check_data("full_data");
        bus_write(1'b1, 8'h02);
        check_status("ovf_cleared");

        // Frame error
        send_frame(8'h5A, odd_par(8'h5A), 1'b0, 0);
        check_status("ferr_status");
        check1("ferr_irq", irq, 1'b0);
        bus_write(1'b1, 8'h04);
        check_status("ferr_cleared");

        // Bad (even) parity
        send_frame(8'hF0, ~odd_par(8'hF0), 1'b1, 0);
        check_status("parity_status");
        check_data("parity_data");
        bus_write(1'b1, 8'h08);
        check_status("parity_cleared");

        // Glitch on ps2_clk shorter than the filter length
        @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h3B, odd_par(8'h3B), 1'b1, 0);
        check_status("glitch_status");
        check_data("glitch_data");

        // Partial frame abandoned by timeout
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 0);
        repeat (TMO + 10) @(negedge clk);
        send_frame(8'h29, odd_par(8'h29), 1'b1, 0);
        check_status("timeout_status");
        check_data("timeout_data");
        check_status("timeout_status_after");

        // Push into a full FIFO in the same cycle as a pop
        for (int k = 0; k < DEPTH; k++) send_frame(8'h60 + 8'(k), odd_par(8'h60 + 8'(k)), 1'b1, 0);
        @(negedge clk); address = 1'b0; cs_r = 1'b1;
        send_frame(8'h77, odd_par(8'h77), 1'b1, 2);
        check_status("collide_status");
        for (int k = 0; k < DEPTH; k++) check_data("collide_data");
        check_status("collide_drained");

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                v = 8'($urandom);
                send_frame(v, ($urandom_range(0, 3) != 0) ? odd_par(v) : ~odd_par(v),
                           1'($urandom_range(0, 7) != 0), 0);
            end else if (op <= 5) check_data("rand_data");
            else if (op == 6)      check_status("rand_status");
            else if (op == 7)      bus_write(1'b1, 8'($urandom));
            else if (op == 8)      bus_write(1'b0, 8'($urandom));
            else                   check1("rand_irq", irq, q.size() != 0);
        end
        check_status("rand_final_status");

        // Reset asserted mid-frame while a STATUS read is in progress
        send_frame(8'h11, odd_par(8'h11), 1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk); address = 1'b1; cs_r = 1'b1;
        #1;
        rb = data_bus;
        check8("pre_reset_status", rb, model_status());
        reset = 1'b1;
        #1;
        q.delete(); m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
        rb = data_bus;
        check8("reset_mid_status", rb, 8'h00);
        check1("reset_mid_irq", irq, 1'b0);
        @(negedge clk); reset = 1'b0; cs_r = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h42, odd_par(8'h42), 1'b1, 0);
        check_status("post_reset_status");
        check_data("post_reset_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Bus-mapped PS/2 keyboard receiver on the shared 8-bit data bus, alongside the gpu and ram.
- Deserialises 11-bit PS/2 frames into scan-code bytes and buffers them in a small FIFO.
- The CPU reads the buffered bytes through a data register and a status register.
- Board decode drives cs_w/cs_r exactly as for the gpu: chip select gated with write/read.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, 2..64.
- FILTER_LEN, 4, consecutive equal synchronised samples required to accept a ps2_clk level change.
- TIMEOUT, 2000, clk cycles without an accepted ps2_clk falling edge that aborts a partial frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_bus  inout  8  shared data bus; driven only while cs_r=1, high-Z otherwise.
- address  in  1  register select: 0 = DATA, 1 = STATUS.
- cs_w  in  1  write strobe (chip select & write).
- cs_r  in  1  read strobe (chip select & read).
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset: FIFO empty, status flags 0, FSM IDLE, irq=0, data_bus high-Z, filter state = 1 (bus idle high).
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filtered clock: changes level only after FILTER_LEN consecutive synchronised samples differ from the current filtered level.
- A falling edge (filtered 1->0) produces a one-cycle sample pulse; ps2_data is sampled on that pulse.
- FSM states and transitions, all on sample pulses:
  - IDLE: data=0 -> DATA with bit counter 0; data=1 -> stay IDLE.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: data=1 and frame valid -> push the byte. data=0 -> set FERR and drop the byte. Always -> IDLE.
- Timeout: in any state other than IDLE, TIMEOUT cycles with no sample pulse -> IDLE. The partial byte is dropped silently.
- Push into a full FIFO: byte dropped, OVF set; FIFO contents unchanged.
- Reading DATA (address=0):
  - While cs_r=1, data_bus shows the FIFO head combinationally; 0x00 if the FIFO is empty.
  - Pop occurs in the cycle after cs_r falls, when the read was at address 0 and the FIFO was non-empty.
  - A read held for many cycles pops exactly once.
- Reading STATUS (address=1) returns {4'b0, PERR, FERR, OVF, NE}.
  - NE = FIFO non-empty.
  - OVF, FERR, PERR are sticky.
- Writing STATUS: on any cycle with cs_w=1 and address=1, flags set by 1-bits of data_bus[3:1] are cleared. Writing DATA is ignored.
- Simultaneous push and pop in one cycle: both take effect; occupancy is unchanged. A full FIFO with a simultaneous pop accepts the push with no OVF.
- Simultaneous flag set and clear-write in one cycle: set wins.
- Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
- irq = NE, registered; it follows the FIFO state with 1-cycle latency.
- Reset asserted mid-frame or mid-read: immediate return to reset state; the FIFO is flushed.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: at STOP, the frame is valid only if the 8 data bits plus the parity bit have odd parity. On a mismatch, the byte is dropped and PERR is set.
- Undefined: the parity bit is ignored, PERR is tied to 0, and all frames with a good stop bit are pushed.

Test Plan:
- Basic receive: send frame 0x1C with correct odd parity and stop=1; wait; read STATUS -> 0x01, irq=1. Read DATA -> 0x1C. Next STATUS read -> 0x00; irq=0 one cycle later.
- Ordering and full: send 9 bytes 0x01..0x09 with FIFO_DEPTH=8. STATUS -> 0x03 (NE+OVF). Eight DATA reads return 0x01..0x08. Write STATUS 0x02 -> STATUS reads 0x00.
- Frame error: send 0x5A with stop=0. STATUS -> 0x04 and FIFO empty. Write 0x04 -> 0x00.
- Parity (PS2_PARITY_CHECK_EN defined): send 0xF0 with even parity. STATUS -> 0x08 and no byte stored. With the macro undefined, the same frame gives STATUS -> 0x01 and DATA = 0xF0.
- Glitch and timeout:
  - A 2-cycle low pulse on ps2_clk (FILTER_LEN=4): no bit sampled.
  - Send start plus 3 bits, then idle for TIMEOUT+10 cycles, then a full 0x29 frame: only 0x29 is stored, with no flags set.
- Push/pop collision and reset:
  - FIFO full; a pop coincides with a push of 0x77: OVF stays 0 and the last entry read is 0x77.
  - Reset mid-frame: STATUS -> 0x00 and irq=0 immediately.
